stopwatch_bcd: RTL and testbench
================================

Name: stopwatch_bcd

Overview:
- Downstream consumer of the clock prescaler's scaled output.
- Counts prescaler tick rising edges as hundredths of a second into four BCD digits, range 00.00–59.99.
- A start/stop/clear FSM controls counting.
- Runs entirely on the system clock: the tick is an enable sampled in the clk domain, never used as a clock. Outputs drive the seven-segment display mux.

Parameters:
- TOP_MAX, 5, maximum value of the most-significant digit d3 (tens of seconds); legal values 1–9.
- SATURATE, 0, 0 = wrap to 00.00 past full scale; 1 = hold at full scale and pause.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous active-low reset; 0 = reset.
- tick  input  1  prescaler output, synchronous to clk; each 0->1 transition is one count event.
- start_stop  input  1  debounced button, synchronous; rising edge toggles run/pause.
- clear  input  1  debounced button, synchronous, level-sensitive; 1 = clear.
- d0  output  4  BCD hundredths, 0–9.
- d1  output  4  BCD tenths, 0–9.
- d2  output  4  BCD seconds units, 0–9.
- d3  output  4  BCD seconds tens, 0–TOP_MAX.
- running  output  1  1 while the FSM is in RUN.
- ovf  output  1  sticky full-scale-reached flag.

Behaviour:
- Reset (rst=0, asynchronous, immediate): state=IDLE; d0..d3=0; running=0; ovf=0; tick_d=0; ss_d=0. Release is synchronous to the next posedge.
- Edge detect: registered copies tick_d and ss_d.
  - tick_ev = tick & ~tick_d.
  - ss_ev = start_stop & ~ss_d.
  - A held input produces exactly one event.
  - tick high in the first cycle after reset counts as an edge.
- FSM states: IDLE, RUN, PAUSE; all registered.
  - clear=1, any state -> IDLE; digits=0; ovf=0. clear has priority over ss_ev and tick_ev in the same cycle.
  - IDLE + ss_ev -> RUN.
  - RUN + ss_ev -> PAUSE.
  - PAUSE + ss_ev -> RUN, counting resumes from the held value.
- running = (state==RUN), registered; it changes on the same edge as the state.
- Counting: a digit update happens on a posedge where the current state is RUN, tick_ev=1 and clear=0.
  - Result is visible in the following cycle; latency from tick rising to digit change is one clk.
  - tick_ev in the cycle that moves IDLE/PAUSE->RUN is not counted.
  - tick_ev in the cycle that moves RUN->PAUSE is counted.
- BCD increment:
  - d0 9->0 carries into d1; d1 9->0 carries into d2; d2 9->0 carries into d3.
  - Digits never hold values above 9 (d3 never above TOP_MAX).
  - Non-carrying digits hold.
- Full scale (d3=TOP_MAX, d2=9, d1=9, d0=9) plus a counted tick:
  - SATURATE=0: all digits -> 0, ovf -> 1, state stays RUN.
  - SATURATE=1: digits hold, ovf -> 1, state -> PAUSE.
  - ss_ev in the same cycle: the SATURATE=1 forced PAUSE wins; the SATURATE=0 case follows the normal RUN->PAUSE rule.
- ovf is sticky; only clear or rst return it to 0. It stays 1 through further wraps.
- Reset mid-count: all outputs go to reset values immediately, without waiting for clk.
- No combinational path from any input to any output.

Test Plan:
- Reset: assert rst=0 mid-RUN at value 12.34 -> outputs 00.00 and running=0 within the same cycle, before the next posedge; stay IDLE after release.
- Start and count: one-cycle start_stop pulse, then 123 tick pulses (1 clk high, 49 low) -> d3..d0 = 0,1,2,3; running=1; each digit change exactly 1 clk after the tick rising edge.
- Pause/resume and hold: hold start_stop high for 20 cycles -> single toggle to PAUSE; 10 ticks in PAUSE -> digits unchanged; pulse again, 5 ticks -> value advances by 0.05.
- Wrap (SATURATE=0): preload by counting to 59.99, one more tick -> 00.00, ovf=1, running=1; further ticks keep ovf=1.
- Saturate (SATURATE=1): same stimulus -> stays 59.99, ovf=1, running=0; then clear=1 -> 00.00, ovf=0, IDLE.
- Simultaneous events: clear, start_stop rising and tick rising in one cycle while RUN at 00.07 -> next cycle IDLE at 00.00. start_stop and tick rising together from PAUSE -> RUN, tick not counted.

Source files
------------

// File: rtl/stopwatch_bcd_if.sv
// stopwatch_bcd_if: control inputs and BCD display outputs of the stopwatch.
// master drives the buttons/tick and reads the display; slave is the stopwatch itself.
`default_nettype none

interface stopwatch_bcd_if;
  logic       tick;
  logic       start_stop;
  logic       clear;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic       running;
  logic       ovf;

  modport master (
    output tick, start_stop, clear,
    input  d0, d1, d2, d3, running, ovf
  );

  modport slave (
    input  tick, start_stop, clear,
    output d0, d1, d2, d3, running, ovf
  );
endinterface

`default_nettype wire

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: counts tick rising edges as hundredths into four BCD digits (00.00 .. TOP_MAX9.99)
// under a start/stop/clear FSM; all outputs registered, reset asynchronous active-low.
`default_nettype none

module stopwatch_bcd #(
  parameter int TOP_MAX  = 5,
  parameter bit SATURATE = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  stopwatch_bcd_if.slave  bus
);

  localparam logic [3:0] TOP  = 4'(TOP_MAX);
  localparam logic [3:0] NINE = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t     state, nxt_state;
  logic       tick_d, ss_d;
  logic [3:0] cur_d0, cur_d1, cur_d2, cur_d3;
  logic [3:0] nxt_d0, nxt_d1, nxt_d2, nxt_d3;
  logic       cur_ovf, nxt_ovf;
  logic       cur_running;
  logic       tick_ev, ss_ev, full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tick_d      <= 1'b0;
      ss_d        <= 1'b0;
      cur_d0      <= 4'd0;
      cur_d1      <= 4'd0;
      cur_d2      <= 4'd0;
      cur_d3      <= 4'd0;
      cur_ovf     <= 1'b0;
      cur_running <= 1'b0;
    end else begin
      state       <= nxt_state;
      tick_d      <= bus.tick;
      ss_d        <= bus.start_stop;
      cur_d0      <= nxt_d0;
      cur_d1      <= nxt_d1;
      cur_d2      <= nxt_d2;
      cur_d3      <= nxt_d3;
      cur_ovf     <= nxt_ovf;
      cur_running <= (nxt_state == RUN);
    end
  end

  always_comb begin
    tick_ev   = bus.tick & ~tick_d;
    ss_ev     = bus.start_stop & ~ss_d;
    full      = (cur_d3 == TOP) && (cur_d2 == NINE) && (cur_d1 == NINE) && (cur_d0 == NINE);
    nxt_state = state;
    nxt_d0    = cur_d0;
    nxt_d1    = cur_d1;
    nxt_d2    = cur_d2;
    nxt_d3    = cur_d3;
    nxt_ovf   = cur_ovf;

    if (bus.clear) begin
      nxt_state = IDLE;
      nxt_d0    = 4'd0;
      nxt_d1    = 4'd0;
      nxt_d2    = 4'd0;
      nxt_d3    = 4'd0;
      nxt_ovf   = 1'b0;
    end else begin
      case (state)
        IDLE:    if (ss_ev) nxt_state = RUN;
        RUN:     if (ss_ev) nxt_state = PAUSE;
        PAUSE:   if (ss_ev) nxt_state = RUN;
        default: nxt_state = IDLE;
      endcase

      // Counting uses the current state, so the tick that starts a run is dropped
      // while the tick that coincides with a pause is still counted.
      if (state == RUN && tick_ev) begin
        if (full) begin
          nxt_ovf = 1'b1;
          if (SATURATE) begin
            nxt_state = PAUSE;
          end else begin
            nxt_d0 = 4'd0;
            nxt_d1 = 4'd0;
            nxt_d2 = 4'd0;
            nxt_d3 = 4'd0;
          end
        end else if (cur_d0 != NINE) begin
          nxt_d0 = cur_d0 + 4'd1;
        end else begin
          nxt_d0 = 4'd0;
          if (cur_d1 != NINE) begin
            nxt_d1 = cur_d1 + 4'd1;
          end else begin
            nxt_d1 = 4'd0;
            if (cur_d2 != NINE) begin
              nxt_d2 = cur_d2 + 4'd1;
            end else begin
              nxt_d2 = 4'd0;
              nxt_d3 = cur_d3 + 4'd1;
            end
          end
        end
      end
    end
  end

  assign bus.d0      = cur_d0;
  assign bus.d1      = cur_d1;
  assign bus.d2      = cur_d2;
  assign bus.d3      = cur_d3;
  assign bus.running = cur_running;
  assign bus.ovf     = cur_ovf;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_bcd.sv
// tb_stopwatch_bcd: drives a wrapping and a saturating stopwatch with identical directed stimulus;
// expectations are queued with their due cycle and a negedge monitor pops and compares them.
`default_nettype none

module tb_stopwatch_bcd;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stopwatch_bcd_if bw ();
  stopwatch_bcd_if bs ();

  stopwatch_bcd #(.TOP_MAX(5), .SATURATE(1'b0)) dut_w (.clk(clk), .rst(rst), .bus(bw));
  stopwatch_bcd #(.TOP_MAX(5), .SATURATE(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(bs));

  typedef struct {
    int          cyc;
    int          sel;
    logic [17:0] val;
    string       name;
  } exp_t;

  exp_t q[$];

  // Hand-tracked expected state per DUT: hundredths count, running, overflow (index 1 = saturating)
  int m_cnt[2];
  bit m_run[2];
  bit m_ovf[2];

  function automatic logic [17:0] pack(int c, bit r, bit o);
    logic [3:0] a, b, e, f;
    a = 4'(c / 1000);
    b = 4'((c / 100) % 10);
    e = 4'((c / 10) % 10);
    f = 4'(c % 10);
    return {a, b, e, f, r, o};
  endfunction

  function automatic void push_exp(int dly, string nm);
    for (int s = 0; s < 2; s++) begin
      exp_t e;
      e.cyc  = cyc + dly;
      e.sel  = s;
      e.val  = pack(m_cnt[s], m_run[s], m_ovf[s]);
      e.name = nm;
      q.push_back(e);
    end
  endfunction

  exp_t        mon_e;
  logic [17:0] mon_act;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e   = q.pop_front();
      mon_act = (mon_e.sel == 1) ? {bs.d3, bs.d2, bs.d1, bs.d0, bs.running, bs.ovf}
                                 : {bw.d3, bw.d2, bw.d1, bw.d0, bw.running, bw.ovf};
      n_total++;
      if (mon_e.cyc != cyc)
        $display("FAIL %s dut=%0d: check due at cycle %0d reached only at cycle %0d",
                 mon_e.name, mon_e.sel, mon_e.cyc, cyc);
      else if (mon_act === mon_e.val)
        n_pass++;
      else
        $display("FAIL %s dut=%0d cyc=%0d actual=%h%h.%h%h run=%b ovf=%b required=%h%h.%h%h run=%b ovf=%b",
                 mon_e.name, mon_e.sel, cyc,
                 mon_act[17:14], mon_act[13:10], mon_act[9:6], mon_act[5:2], mon_act[1], mon_act[0],
                 mon_e.val[17:14], mon_e.val[13:10], mon_e.val[9:6], mon_e.val[5:2],
                 mon_e.val[1], mon_e.val[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit t, bit ss, bit clr);
    bw.tick = t;  bw.start_stop = ss;  bw.clear = clr;
    bs.tick = t;  bs.start_stop = ss;  bs.clear = clr;
  endtask

  task automatic model_tick();
    for (int s = 0; s < 2; s++) begin
      if (m_run[s]) begin
        if (m_cnt[s] == 5999) begin
          m_ovf[s] = 1'b1;
          if (s == 1) m_run[s] = 1'b0;
          else        m_cnt[s] = 0;
        end else begin
          m_cnt[s]++;
        end
      end
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0;
      m_run[s] = 1'b0;
      m_ovf[s] = 1'b0;
    end
  endtask

  task automatic model_toggle();
    for (int s = 0; s < 2; s++) m_run[s] = !m_run[s];
  endtask

  task automatic press(string nm);
    drive(1'b0, 1'b1, 1'b0);
    model_toggle();
    push_exp(1, nm);
    step();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  // One tick: high for a cycle, then low; optionally check old value now and new value a clk later
  task automatic tick_pulse(int low, bit chk, string nm);
    drive(1'b1, 1'b0, 1'b0);
    if (chk) push_exp(0, {nm, "_pre"});
    model_tick();
    if (chk) push_exp(1, {nm, "_post"});
    step();
    drive(1'b0, 1'b0, 1'b0);
    repeat (low) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    model_clear();
    rst = 1'b0;
    step();
    push_exp(0, "reset_state");
    step();
    rst = 1'b1;
    step();

    // start and count 123 ticks at 1 high / 49 low
    press("start");
    for (int i = 0; i < 123; i++) tick_pulse(49, (i < 3) || (i == 122), "count");

    // long start_stop hold toggles once
    drive(1'b0, 1'b1, 1'b0);
    model_toggle();
    push_exp(1, "hold_press");
    repeat (20) step();
    push_exp(0, "hold_single_toggle");
    drive(1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 10; i++) tick_pulse(49, (i == 0) || (i == 9), "paused_tick");
    press("resume");
    for (int i = 0; i < 5; i++) tick_pulse(49, i == 4, "resumed");

    // start_stop and tick rising together from PAUSE: resume, tick dropped
    press("pause2");
    step();
    drive(1'b1, 1'b1, 1'b0);
    model_tick();
    model_toggle();
    push_exp(1, "ss_tick_from_pause");
    step();
    drive(1'b0, 1'b0, 1'b0);
    step();
    push_exp(0, "ss_tick_settled");

    // reach 12.34 then reset asynchronously mid-cycle
    for (int i = 0; i < 1106; i++) tick_pulse(1, i == 1105, "to_1234");
    rst = 1'b0;
    model_clear();
    push_exp(0, "async_reset");
    step();
    step();
    rst = 1'b1;
    step();
    tick_pulse(3, 1'b1, "idle_after_reset");

    // clear beats start_stop and tick in the same cycle
    press("start3");
    for (int i = 0; i < 7; i++) tick_pulse(1, i == 6, "to_007");
    drive(1'b1, 1'b1, 1'b1);
    model_clear();
    push_exp(1, "clear_priority");
    step();
    drive(1'b0, 1'b0, 1'b0);
    step();
    push_exp(0, "clear_idle");

    // full scale: wrap (dut 0) versus saturate (dut 1)
    press("start4");
    for (int i = 0; i < 5999; i++) tick_pulse(1, i == 5998, "to_5999");
    tick_pulse(3, 1'b1, "full_scale");
    for (int i = 0; i < 3; i++) tick_pulse(1, i == 2, "after_full");
    drive(1'b0, 1'b0, 1'b1);
    model_clear();
    push_exp(1, "clear_after_full");
    step();
    drive(1'b0, 1'b0, 1'b0);
    step();
    push_exp(0, "idle_after_clear");

    repeat (3) step();
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      n_total++;
      $display("FAIL %s dut=%0d: never checked (due cycle %0d, now %0d)", mon_e.name, mon_e.sel, mon_e.cyc, cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
